// File: rtl/sipo_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Serial-in / parallel-out signal bundle between line driver, receiver and word consumer.
interface sipo_frame_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              sin;
    logic              en;
    logic              dout_ready;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    // master drives the serial line and consumes words; slave is the receiver
    modport master (
        output sin, en, dout_ready,
        input  dout, dout_valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        input  sin, en, dout_ready,
        output dout, dout_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for a received word and its parity status.
module sipo_out_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_perr,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_valid,
    output logic              o_perr,
    output logic              o_free_c
);

    logic [DATA_W-1:0] r_dout;
    logic              r_valid;
    logic              r_perr;

    // a full buffer that is draining this cycle can take a new word on the same edge
    assign o_free_c = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
        end else if (i_load) begin
            r_dout  <= i_data;
            r_perr  <= i_perr;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_dout  = r_dout;
    assign o_valid = r_valid;
    assign o_perr  = r_perr;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, MSB-first data, optional even parity, stop bit.
module sipo_frame_rx
    import sipo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    sipo_frame_rx_if.slave bus
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_DATA   = 2'(DATA);
    localparam logic [1:0] ST_PARITY = 2'(PARITY);
    localparam logic [1:0] ST_STOP   = 2'(STOP);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_perr;
    logic              r_busy;
    logic              r_frame_err;
    logic              r_overrun;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic              w_perr_nxt;
    logic              w_stop_good;
    logic              w_stop_bad;
    logic              w_free;
    logic              w_load;
    logic              w_perr_out;

    // frame sequencing; everything here advances only on bit-sample cycles
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_perr_nxt  = r_perr;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        if (bus.en) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.sin == START_BIT) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_DATA: begin
                    w_shreg_nxt = {r_shreg[DATA_W-2:0], bus.sin};
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    w_perr_nxt  = (^r_shreg) ^ bus.sin;
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (bus.sin == STOP_BIT) begin
                        w_stop_good = 1'b1;
                    end else begin
                        w_stop_bad = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // a good frame is discarded (overrun) only when the buffer cannot take it
    assign w_load     = w_stop_good && w_free;
    assign w_perr_out = PARITY_EN ? r_perr : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_perr      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_perr      <= w_perr_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_stop_good && !w_free;
        end
    end

    sipo_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_data   (r_shreg),
        .i_perr   (w_perr_out),
        .i_ready  (bus.dout_ready),
        .o_dout   (bus.dout),
        .o_valid  (bus.dout_valid),
        .o_perr   (bus.parity_err),
        .o_free_c (w_free)
    );

    assign bus.busy      = r_busy;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Randomized bench for sipo_frame_rx against a frame-level reference model.
module tb_sipo_frame_rx;
    import sipo_pkg::*;

    localparam int unsigned DW   = 8;
    localparam int unsigned FLEN = 1 + DW + 1 + 1;

    logic clk;
    logic rst;

    sipo_frame_rx_if #(.DATA_W(DW)) bus ();

    sipo_frame_rx #(
        .DATA_W    (DW),
        .PARITY_EN (1'b1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int busy_cnt;

    // reference model: position within the frame, collected bits, buffer contents
    int          m_pos;
    logic        m_bits[$];
    logic        m_valid;
    logic [31:0] m_dout;
    logic        m_perr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pick_rdy(input int mode);
        if (mode == 2) return 1'($urandom % 2);
        return (mode == 1);
    endfunction

    function automatic logic even_par(input logic [DW-1:0] d);
        return 1'($countones(d) % 2);
    endfunction

    task automatic model_reset();
        m_pos   = 0;
        m_bits.delete();
        m_valid = 1'b0;
        m_dout  = '0;
        m_perr  = 1'b0;
    endtask

    // one clock: drive, advance the model with the values present at the edge, compare
    task automatic step(input logic s, input logic e, input logic r);
        logic        drain;
        logic        loaded;
        logic        fe;
        logic        ov;
        logic [31:0] word;
        int          ones;
        bus.sin        = s;
        bus.en         = e;
        bus.dout_ready = r;
        @(posedge clk);
        #1;
        drain  = m_valid && r;
        loaded = 1'b0;
        fe     = 1'b0;
        ov     = 1'b0;
        if (e) begin
            if (m_pos == 0) begin
                if (s == START_BIT) begin
                    m_pos = 1;
                    m_bits.delete();
                end
            end else if (m_pos < int'(FLEN) - 1) begin
                m_bits.push_back(s);
                m_pos++;
            end else begin
                m_pos = 0;
                if (s != STOP_BIT) begin
                    fe = 1'b1;
                end else begin
                    word = 0;
                    ones = 0;
                    for (int i = 0; i < int'(DW); i++) word = word * 2 + 32'(m_bits[i]);
                    foreach (m_bits[i]) ones += int'(m_bits[i]);
                    if (!m_valid || drain) begin
                        m_valid = 1'b1;
                        m_dout  = word;
                        m_perr  = 1'(ones % 2);
                        loaded  = 1'b1;
                    end else begin
                        ov = 1'b1;
                    end
                end
            end
        end
        if (!loaded && drain) m_valid = 1'b0;
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
        if (m_valid) begin
            chk("dout", 32'(bus.dout), m_dout);
            chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
        end
        chk("frame_err", 32'(bus.frame_err), 32'(fe));
        chk("overrun", 32'(bus.overrun), 32'(ov));
        chk("busy", 32'(bus.busy), 32'(m_pos != 0));
        if (bus.busy) busy_cnt++;
    endtask

    // en_mode: 0 = en every cycle, 1 = one en=0 cycle before each bit, 2 = random gaps
    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stp,
                              input int en_mode, input int rdy_mode);
        logic fr[$];
        fr.push_back(START_BIT);
        for (int i = int'(DW) - 1; i >= 0; i--) fr.push_back(d[i]);
        fr.push_back(par);
        fr.push_back(stp);
        foreach (fr[i]) begin
            if (en_mode == 1) begin
                step(1'($urandom % 2), 1'b0, pick_rdy(rdy_mode));
            end else if (en_mode == 2) begin
                while ($urandom % 4 == 0) step(1'($urandom % 2), 1'b0, pick_rdy(rdy_mode));
            end
            step(fr[i], 1'b1, pick_rdy(rdy_mode));
        end
    endtask

    task automatic idle(input int n, input int rdy_mode);
        for (int i = 0; i < n; i++) step(IDLE_LEVEL, 1'($urandom % 2), pick_rdy(rdy_mode));
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          p;
        n_checks       = 0;
        n_errors       = 0;
        busy_cnt       = 0;
        rst            = 1'b0;
        bus.sin        = IDLE_LEVEL;
        bus.en         = 1'b0;
        bus.dout_ready = 1'b0;
        model_reset();
        #23;
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_flags", {29'd0, bus.parity_err, bus.frame_err, bus.overrun}, 0);
        rst = 1'b1;
        #4;

        // basic frame
        busy_cnt = 0;
        send_frame(8'hA5, 1'b0, 1'b0, 0, 1);
        chk("s1_dout", 32'(bus.dout), 32'h00A5);
        chk("s1_valid", 32'(bus.dout_valid), 1);
        chk("s1_perr", 32'(bus.parity_err), 0);
        chk("s1_busy_len", 32'(busy_cnt), 10);
        idle(2, 1);

        // bad parity, then bad stop bit
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1);
        chk("s2_perr", 32'(bus.parity_err), 1);
        idle(1, 1);
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1);
        chk("s2_frame_err", 32'(bus.frame_err), 1);
        idle(1, 1);
        chk("s2_fe_pulse", 32'(bus.frame_err), 0);

        // overrun with consumer stalled
        send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
        send_frame(8'hFF, 1'b0, 1'b0, 0, 0);
        chk("s3_overrun", 32'(bus.overrun), 1);
        chk("s3_dout_held", 32'(bus.dout), 32'h003C);
        step(IDLE_LEVEL, 1'b1, 1'b1);
        chk("s3_drained", 32'(bus.dout_valid), 0);
        idle(1, 1);

        // back-to-back frames with no gap
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1);
        send_frame(8'hFF, 1'b0, 1'b0, 0, 1);
        send_frame(8'h00, 1'b0, 1'b0, 0, 1);
        chk("s4_last", 32'(bus.dout), 32'h0000);
        idle(2, 1);

        // half-rate enable
        busy_cnt = 0;
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1);
        chk("s5_dout", 32'(bus.dout), 32'h00A5);
        chk("s5_busy_len", 32'(busy_cnt), 20);
        idle(2, 1);

        // reset in the middle of a frame
        step(START_BIT, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'(i % 2), 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("s6_rst_busy", 32'(bus.busy), 0);
        chk("s6_rst_valid", 32'(bus.dout_valid), 0);
        chk("s6_rst_dout", 32'(bus.dout), 0);
        model_reset();
        #3;
        rst = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 0, 1);
        chk("s6_dout", 32'(bus.dout), 32'h005A);
        chk("s6_perr", 32'(bus.parity_err), 0);
        idle(2, 1);

        // random traffic
        for (int n = 0; n < 80; n++) begin
            d = DW'($urandom);
            p = even_par(d) ^ ($urandom % 5 == 0);
            send_frame(d, p, 1'($urandom % 8 == 0), int'($urandom % 3), 2);
            if ($urandom % 2 == 0) idle(int'($urandom % 4), 2);
        end
        idle(4, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
